// File: rtl/fib_pkg.sv
// Shared definitions for the Fibonacci display path: converter FSM states,
// the BCD blank code, the generator term width, and the helper that sizes
// a BCD field for a given binary width.
package fib_pkg;

    // Converter control states.
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        SHIFT = 2'd1,
        DONE  = 2'd2
    } fib_state_t;

    // Nibble code the display path treats as "no digit here".
    localparam logic [3:0] BCD_BLANK = 4'hF;

    // Width of the terms produced by the Fibonacci generator.
    localparam int FIB_WIDTH = 32;

    // Decimal digits needed for a w-bit unsigned value:
    // ceil(w * log10(2)), with log10(2) approximated as 0.30103.
    function automatic int bcd_digits_for_width(input int w);
        return (w * 30103 + 99999) / 100000;
    endfunction

endpackage

// File: rtl/bcd_digit_adj.sv
// One double-dabble digit correction: a nibble of 5 or more gets +3 so the
// following left shift carries correctly into the next decimal digit.
// Inputs are always 0..9, so the result (at most 12) never overflows 4 bits.
module bcd_digit_adj (
    input  logic [3:0] d,
    output logic [3:0] q
);

    assign q = (d >= 4'd5) ? (d + 4'd3) : d;

endmodule

// File: rtl/fib_bcd_converter.sv
// Binary to packed-BCD converter placed after the Fibonacci generator.
// One term at a time is shifted through an iterative double-dabble engine
// (one bit per clock); the finished result is held until the display path
// takes it.
//
// Build option: FIB_BCD_LEADING_ZERO_BLANK_EN
//   defined   - digits above the most significant nonzero one are driven
//               as BCD_BLANK (digit 0 is always numeric)
//   undefined - leading digits read as 0
// out_ndigits and all timing are the same in both builds.
//
// Handshakes: a transfer happens on a rising clock edge where valid and
// ready are both high. valid never depends on ready. The input side is only
// ready in IDLE, the output side only presents valid in DONE; out_bcd and
// out_ndigits stay stable while out_valid is high and out_ready is low.
module fib_bcd_converter
    import fib_pkg::*;
#(
    parameter int WIDTH  = FIB_WIDTH,
    parameter int DIGITS = 10
) (
    input  logic                          clock,
    input  logic                          reset,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [WIDTH-1:0]              in_data,
    output logic                          out_valid,
    input  logic                          out_ready,
    output logic [4*DIGITS-1:0]           out_bcd,
    output logic [$clog2(DIGITS+1)-1:0]   out_ndigits
);

    localparam int CNT_W = $clog2(WIDTH + 1);
    localparam int NDW   = $clog2(DIGITS + 1);
    localparam int BCD_W = 4 * DIGITS;

    // Refuse to build a BCD field too narrow for the largest input value.
    if (DIGITS < bcd_digits_for_width(WIDTH)) begin : g_digits_too_small
        $error("fib_bcd_converter: DIGITS too small for WIDTH");
    end

    fib_state_t         state;
    logic [WIDTH-1:0]   bin_q;
    logic [BCD_W-1:0]   bcd_q;
    logic [CNT_W-1:0]   cnt_q;

    logic [BCD_W-1:0]   bcd_adj;
    logic [BCD_W-1:0]   bcd_next;
    logic [WIDTH-1:0]   bin_next;
    logic [NDW-1:0]     nd_next;
    logic [BCD_W-1:0]   bcd_disp;

    // Per-digit +3 correction applied before every shift.
    for (genvar i = 0; i < DIGITS; i++) begin : g_adj
        bcd_digit_adj u_adj (
            .d (bcd_q[4*i +: 4]),
            .q (bcd_adj[4*i +: 4])
        );
    end

    // One double-dabble step: {bcd, bin} shifted left by one after correction.
    assign bcd_next = {bcd_adj[BCD_W-2:0], bin_q[WIDTH-1]};
    assign bin_next = {bin_q[WIDTH-2:0], 1'b0};

    // Significant digit count of the value the current step produces:
    // index of the highest nonzero digit plus one, never less than one.
    always_comb begin
        nd_next = NDW'(1);
        for (int i = 1; i < DIGITS; i++) begin
            if (bcd_next[4*i +: 4] != 4'd0) begin
                nd_next = NDW'(i + 1);
            end
        end
    end

    // Display form of the result; optionally blanks the leading zeros.
    always_comb begin
        bcd_disp = bcd_next;
`ifdef FIB_BCD_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            if (i >= int'(nd_next)) begin
                bcd_disp[4*i +: 4] = BCD_BLANK;
            end
        end
`endif
    end

    // Control FSM and datapath registers; all outputs are registered.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            bin_q       <= '0;
            bcd_q       <= '0;
            cnt_q       <= '0;
            in_ready    <= 1'b1;
            out_valid   <= 1'b0;
            out_bcd     <= '0;
            out_ndigits <= NDW'(1);
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        bin_q    <= in_data;
                        bcd_q    <= '0;
                        cnt_q    <= CNT_W'(WIDTH);
                        in_ready <= 1'b0;
                        state    <= SHIFT;
                    end
                end
                SHIFT: begin
                    bin_q <= bin_next;
                    bcd_q <= bcd_next;
                    cnt_q <= cnt_q - 1'b1;
                    if (cnt_q == CNT_W'(1)) begin
                        out_bcd     <= bcd_disp;
                        out_ndigits <= nd_next;
                        out_valid   <= 1'b1;
                        state       <= DONE;
                    end
                end
                DONE: begin
                    if (out_valid && out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_fib_bcd_converter.sv
// Bench for fib_bcd_converter: expected BCD results come from a decimal
// division model, are queued when a term is accepted and compared when the
// converter delivers. Build with FIB_BCD_LEADING_ZERO_BLANK_EN to expect
// blanked leading digits.
module tb_fib_bcd_converter;

    localparam int WIDTH  = 32;
    localparam int DIGITS = 10;
    localparam int NDW    = $clog2(DIGITS + 1);
    localparam int EXP_W  = 4 * DIGITS + NDW;

    logic                  clock;
    logic                  reset;
    logic                  in_valid;
    logic                  in_ready;
    logic [WIDTH-1:0]      in_data;
    logic                  out_valid;
    logic                  out_ready;
    logic [4*DIGITS-1:0]   out_bcd;
    logic [NDW-1:0]        out_ndigits;

    logic [EXP_W-1:0] exp_q[$];
    int n_checks = 0;
    int n_errors = 0;

    fib_bcd_converter #(.WIDTH(WIDTH), .DIGITS(DIGITS)) dut (
        .clock       (clock),
        .reset       (reset),
        .in_valid    (in_valid),
        .in_ready    (in_ready),
        .in_data     (in_data),
        .out_valid   (out_valid),
        .out_ready   (out_ready),
        .out_bcd     (out_bcd),
        .out_ndigits (out_ndigits)
    );

    // ---------------- clock / reset ----------------
    initial clock = 1'b0;
    always #5 clock = ~clock;

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    // ---------------- model / checking ----------------
    function automatic int model_nd(input logic [WIDTH-1:0] v);
        longint x;
        int n;
        x = longint'(v);
        n = 0;
        do begin
            n++;
            x = x / 10;
        end while (x != 0);
        return n;
    endfunction

    function automatic logic [4*DIGITS-1:0] model_bcd(input logic [WIDTH-1:0] v);
        logic [4*DIGITS-1:0] r;
        longint x;
        int nd;
        r  = '0;
        x  = longint'(v);
        nd = model_nd(v);
        for (int i = 0; i < DIGITS; i++) begin
            r[4*i +: 4] = 4'(x % 10);
            x = x / 10;
        end
`ifdef FIB_BCD_LEADING_ZERO_BLANK_EN
        for (int i = 1; i < DIGITS; i++) begin
            if (i >= nd) r[4*i +: 4] = 4'hF;
        end
`endif
        return r;
    endfunction

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got=%0h expected=%0h", tag, got, exp);
        end
    endtask

    // ---------------- driver tasks ----------------
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic send(input logic [WIDTH-1:0] v);
        int waited;
        waited = 0;
        while (!in_ready && waited < 200) begin
            step();
            waited++;
        end
        check("send_ready", 64'(in_ready), 64'd1);
        in_valid = 1'b1;
        in_data  = v;
        step();
        in_valid = 1'b0;
        exp_q.push_back({model_bcd(v), NDW'(model_nd(v))});
    endtask

    task automatic wait_out_valid(input string tag);
        int waited;
        waited = 0;
        while (!out_valid && waited < 200) begin
            step();
            waited++;
        end
        check(tag, 64'(out_valid), 64'd1);
    endtask

    // ---------------- scoreboard ----------------
    always @(negedge clock) begin
        if (!reset && out_valid && out_ready) begin
            if (exp_q.size() == 0) begin
                check("unexpected_out", 64'(exp_q.size()), 64'd1);
            end else begin
                logic [EXP_W-1:0] e;
                e = exp_q.pop_front();
                check("sb_bcd", 64'(out_bcd), 64'(e[EXP_W-1:NDW]));
                check("sb_ndigits", 64'(out_ndigits), 64'(e[NDW-1:0]));
            end
        end
    end

    // ---------------- stimulus ----------------
    logic [WIDTH-1:0] fib_terms[10] = '{1, 2, 3, 5, 8, 13, 21, 34, 55, 89};

    initial begin
        int cnt;
        logic [4*DIGITS-1:0] hold_exp;

        reset     = 1'b1;
        in_valid  = 1'b0;
        in_data   = '0;
        out_ready = 1'b1;
        repeat (3) step();
        reset = 1'b0;
        step();

        check("rst_out_valid", 64'(out_valid), 64'd0);
        check("rst_in_ready", 64'(in_ready), 64'd1);
        check("rst_out_bcd", 64'(out_bcd), 64'd0);
        check("rst_ndigits", 64'(out_ndigits), 64'd1);

        // zero: latency from accept to out_valid
        send(32'd0);
        cnt = 0;
        while (!out_valid && cnt < 100) begin
            step();
            cnt++;
        end
        check("latency_zero", 64'(cnt), 64'd32);

        // largest value
        send(32'hFFFF_FFFF);
        wait_out_valid("max_valid");

        // Fibonacci stream, out_ready high: in_ready low 33 cycles per term
        for (int t = 0; t < 10; t++) begin
            send(fib_terms[t]);
            cnt = 0;
            while (!in_ready && cnt < 100) begin
                cnt++;
                step();
            end
            check("busy_cycles", 64'(cnt), 64'd33);
        end

        // F47 with back-pressure and a noisy input bus
        out_ready = 1'b0;
        send(32'd2971215073);
        wait_out_valid("f47_valid");
        hold_exp = model_bcd(32'd2971215073);
        for (int k = 0; k < 7; k++) begin
            in_valid = 1'b1;
            in_data  = $urandom;
            step();
            check("hold_bcd", 64'(out_bcd), 64'(hold_exp));
            check("hold_in_ready", 64'(in_ready), 64'd0);
            check("hold_out_valid", 64'(out_valid), 64'd1);
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check("release_out_valid", 64'(out_valid), 64'd0);
        check("release_in_ready", 64'(in_ready), 64'd1);
        send(32'd987);
        wait_out_valid("v987_valid");
        step();

        // reset in the middle of a conversion
        send(32'd12345);
        repeat (10) step();
        reset = 1'b1;
        #1;
        check("midrst_out_valid", 64'(out_valid), 64'd0);
        check("midrst_in_ready", 64'(in_ready), 64'd1);
        check("midrst_out_bcd", 64'(out_bcd), 64'd0);
        check("midrst_ndigits", 64'(out_ndigits), 64'd1);
        void'(exp_q.pop_back());
        step();
        reset = 1'b0;
        step();
        send(32'd610);
        wait_out_valid("v610_valid");
        check("v610_bcd", 64'(out_bcd), 64'(model_bcd(32'd610)));
        check("v610_ndigits", 64'(out_ndigits), 64'd3);

        // drain the scoreboard
        cnt = 0;
        while (exp_q.size() != 0 && cnt < 100) begin
            step();
            cnt++;
        end
        check("sb_drain", 64'(exp_q.size()), 64'd0);

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule

// File: doc/fib_bcd_converter.md
Name: fib_bcd_converter

Overview:
- Stage directly downstream of the Fibonacci generator.
- Takes each 32-bit binary term over a valid/ready handshake and converts it to packed BCD with an iterative shift-add-3 (double-dabble) engine.
- Feeds the BCD display/print path.
- One conversion in flight at a time; results are held until the consumer accepts them.

Parameters:
- WIDTH, 32, binary input width.
- DIGITS, 10, number of BCD output digits. Must satisfy DIGITS >= ceil(WIDTH*0.30103). Violation triggers an elaboration-time error.
- CNT_W, $clog2(WIDTH+1), width of the shift counter (derived, not overridable).

Ports:
- clock  input  1  rising-edge clock.
- reset  input  1  asynchronous, active-high reset.
- in_valid  input  1  in_data holds a term to convert.
- in_ready  output  1  block can accept a term this cycle.
- in_data  input  WIDTH  binary term, unsigned.
- out_valid  output  1  out_bcd/out_ndigits hold a finished result.
- out_ready  input  1  consumer accepts the result this cycle.
- out_bcd  output  4*DIGITS  packed BCD; digit 0 in [3:0], most significant digit at the top.
- out_ndigits  output  $clog2(DIGITS+1)  count of significant digits, 1..DIGITS.

Behaviour:
- Interface: reset and clock as already decided — reset is asynchronous, active-high, named reset; clock is named clock.
- Reset values:
  - out_valid=0, out_bcd=0, out_ndigits=1, in_ready=1.
  - State IDLE; internal shift and count registers = 0.
- FSM states: IDLE, SHIFT, DONE.
- IDLE:
  - in_ready=1.
  - On in_valid&&in_ready: load binary shift reg <= in_data, BCD reg <= 0, count <= WIDTH; go to SHIFT.
- SHIFT:
  - in_ready=0.
  - Each cycle: every BCD digit >=5 gets +3, then {bcd,bin} shifts left by 1 and count decrements.
  - When count reaches 1 and that shift completes: register out_bcd and compute out_ndigits (index of highest nonzero digit +1, minimum 1); out_valid <= 1; go to DONE.
- DONE:
  - in_ready=0; out_valid=1.
  - out_bcd and out_ndigits held stable.
  - On out_valid&&out_ready: out_valid <= 0; go to IDLE.
- Latency: input accepted on edge N; out_valid rises after edge N+WIDTH (32 cycles for defaults).
- Throughput: one term per WIDTH+2 cycles with out_ready tied high. No overlap of accept and deliver.
- Arithmetic: digit adjust is 4-bit, never carries across digits (max 4+3=... digit ≤9 before adjust, ≤12 after, fits). No saturation: any unsigned WIDTH value is representable.
- in_data is ignored outside IDLE; holding in_valid high there has no effect.
- out_ready is ignored outside DONE.
- Reset asserted mid-SHIFT or in DONE: in-flight term discarded, all outputs return to reset values immediately.

Optional Feature:
- Macro FIB_BCD_LEADING_ZERO_BLANK_EN.
- Defined: digits above out_ndigits-1 are driven as 4'hF (blank code) in out_bcd. Digit 0 is always numeric.
- Undefined: leading digits are 4'h0.
- out_ndigits and timing are identical in both builds.

Decomposition:
- Package fib_pkg holds:
  - State enum (IDLE, SHIFT, DONE).
  - Constant BCD_BLANK=4'hF.
  - Constant FIB_WIDTH=32 shared with the generator.
  - Function bcd_digits_for_width(w) used for the parameter check.
- Sub-module bcd_digit_adj: purely combinational; 4-bit in, 4-bit out, adds 3 when the input is >=5. Instantiated DIGITS times by generate.

Test Plan:
- Input 0 -> out_bcd=0x0000000000, out_ndigits=1, out_valid exactly 32 cycles after accept; with blanking, out_bcd=0xFFFFFFFFF0.
- Input 4294967295 -> out_bcd=0x4294967295, out_ndigits=10.
- Stream Fibonacci terms 1,2,3,5,8,13,21,34,55,89 with out_ready=1 -> BCD 0x1..0x89 in order; in_ready low for exactly 33 cycles after each accept.
- Input 2971215073 (F47), out_ready held low 7 cycles with in_valid=1 and in_data changing -> out_bcd stays 0x2971215073, in_ready stays 0; next term accepted only after the handshake.
- Reset pulsed 10 cycles into a conversion of 12345 -> outputs return to reset values at once; a subsequent input 610 yields 0x0000000610, out_ndigits=3.
